// File: rtl/issue_queue_ctl_pkg.sv
// Shared sizing helpers for the issue-queue controller.
package issue_queue_ctl_pkg;

  localparam int MAX_ENTRIES = 16;
  localparam int MAX_CNT_W   = 5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int cnt_w(input int entries);
    return clog2(entries + 1);
  endfunction

  function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_ENTRIES-1:0] v);
    logic [MAX_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_ENTRIES; i++) n = n + MAX_CNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/issue_queue_ctl_if.sv
// Dispatch/issue bundle between the queue controller and its dispatcher/scheduler.
interface issue_queue_ctl_if #(
  parameter int ENTRIES    = 4,
  parameter int LOAD_PORTS = 2,
  parameter int EXE_UNITS  = 2
) ();
  import issue_queue_ctl_pkg::*;

  localparam int CNT_W = cnt_w(ENTRIES);

  logic [LOAD_PORTS-1:0]         iq_loads;
  logic [EXE_UNITS-1:0]          exe_ready;
  logic [ENTRIES-1:0]            ops_ready;
  logic [ENTRIES-1:0]            flush;
  logic [LOAD_PORTS-1:0]         load_accept;
  logic [LOAD_PORTS*ENTRIES-1:0] load;
  logic [EXE_UNITS*ENTRIES-1:0]  issue;
  logic [ENTRIES-1:0]            valid;
  logic [CNT_W-1:0]              count;
  logic                          full;
  logic                          empty;

  modport master (
    output iq_loads, exe_ready, ops_ready, flush,
    input  load_accept, load, issue, valid, count, full, empty
  );

  modport slave (
    input  iq_loads, exe_ready, ops_ready, flush,
    output load_accept, load, issue, valid, count, full, empty
  );

endinterface

// File: rtl/issue_queue_ctl_age_matrix.sv
// Relative-age matrix: older[i][j] set when entry i is older than entry j.
module issue_queue_ctl_age_matrix #(
  parameter int ENTRIES = 4,
  parameter int PORT_W  = 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [ENTRIES-1:0]               i_keep,
  input  logic [ENTRIES-1:0]               i_new,
  input  logic [ENTRIES-1:0][PORT_W-1:0]   i_port,
  output logic [ENTRIES-1:0][ENTRIES-1:0]  o_older
);

  logic [ENTRIES-1:0][ENTRIES-1:0] r_older;
  logic [ENTRIES-1:0][ENTRIES-1:0] w_older_nxt;

  // NOTE: default every bit before the conditional updates so no path leaves a latch.
  always_comb begin
    w_older_nxt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      for (int j = 0; j < ENTRIES; j++) begin
        if (i != j) begin
          if (i_keep[i] && i_keep[j])     w_older_nxt[i][j] = r_older[i][j];
          else if (i_keep[i] && i_new[j]) w_older_nxt[i][j] = 1'b1;
          else if (i_new[i] && i_new[j])  w_older_nxt[i][j] = (i_port[i] < i_port[j]);
        end
      end
    end
  end

  // NOTE: the matrix is a small flop array, so it takes the reset like any other register.
  // NOTE: non-blocking updates keep every flop sampling pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_older <= '0;
    else          r_older <= w_older_nxt;
  end

  assign o_older = r_older;

endmodule

// File: rtl/issue_queue_ctl.sv
// Issue-queue controller: slot allocation for dispatch ports, oldest-ready issue selection.
module issue_queue_ctl
  import issue_queue_ctl_pkg::*;
#(
  parameter int ENTRIES    = 4,
  parameter int LOAD_PORTS = 2,
  parameter int EXE_UNITS  = 2
) (
  input logic              clock,
  input logic              reset_n,
  issue_queue_ctl_if.slave bus
);

  localparam int CNT_W  = cnt_w(ENTRIES);
  localparam int PORT_W = (LOAD_PORTS > 1) ? clog2(LOAD_PORTS) : 1;

  logic [ENTRIES-1:0]                r_valid;
  logic [CNT_W-1:0]                  r_count;
  logic                              r_full;
  logic                              r_empty;

  logic [ENTRIES-1:0][ENTRIES-1:0]   w_older;
  logic [ENTRIES-1:0]                w_free, w_cand, w_col, w_loaded, w_issued, w_keep, w_nv;
  logic [LOAD_PORTS-1:0]             w_accept;
  logic [LOAD_PORTS-1:0][ENTRIES-1:0] w_load;
  logic [EXE_UNITS-1:0][ENTRIES-1:0] w_issue;
  logic [ENTRIES-1:0][PORT_W-1:0]    w_port;
  logic [ENTRIES-1:0][CNT_W-1:0]     w_rank;
  logic [CNT_W-1:0]                  w_nready;
  logic [CNT_W-1:0]                  w_nv_cnt;

  // Only slots empty at the start of the cycle are handed out; each grant removes its slot.
  always_comb begin
    w_free   = ~r_valid;
    w_accept = '0;
    w_load   = '0;
    w_port   = '0;
    for (int p = 0; p < LOAD_PORTS; p++) begin
      if (bus.iq_loads[p]) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (!w_accept[p] && w_free[i]) begin
            w_load[p][i] = 1'b1;
            w_accept[p]  = 1'b1;
            w_free[i]    = 1'b0;
            w_port[i]    = PORT_W'(p);
          end
        end
      end
    end
  end

  // rank = number of older candidates; the n-th ready unit takes the rank-n candidate.
  always_comb begin
    w_cand   = r_valid & bus.ops_ready & ~bus.flush;
    w_col    = '0;
    w_rank   = '0;
    w_issue  = '0;
    w_nready = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      for (int j = 0; j < ENTRIES; j++) w_col[j] = w_older[j][i];
      w_rank[i] = CNT_W'(popcount(MAX_ENTRIES'(w_cand & w_col)));
    end
    for (int k = 0; k < EXE_UNITS; k++) begin
      if (bus.exe_ready[k]) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (w_cand[i] && (w_rank[i] == w_nready)) w_issue[k][i] = 1'b1;
        end
        w_nready = w_nready + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_loaded = '0;
    w_issued = '0;
    for (int p = 0; p < LOAD_PORTS; p++) w_loaded = w_loaded | w_load[p];
    for (int k = 0; k < EXE_UNITS; k++)  w_issued = w_issued | w_issue[k];
    w_keep   = r_valid & ~bus.flush & ~w_issued;
    w_nv     = w_keep | w_loaded;
    w_nv_cnt = CNT_W'(popcount(MAX_ENTRIES'(w_nv)));
  end

  issue_queue_ctl_age_matrix #(
    .ENTRIES (ENTRIES),
    .PORT_W  (PORT_W)
  ) u_age (
    .clock   (clock),
    .reset_n (reset_n),
    .i_keep  (w_keep),
    .i_new   (w_loaded),
    .i_port  (w_port),
    .o_older (w_older)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_valid <= w_nv;
      r_count <= w_nv_cnt;
      r_full  <= &w_nv;
      r_empty <= ~|w_nv;
    end
  end

  assign bus.load_accept = w_accept;
  assign bus.load        = w_load;
  assign bus.issue       = w_issue;
  assign bus.valid       = r_valid;
  assign bus.count       = r_count;
  assign bus.full        = r_full;
  assign bus.empty       = r_empty;

endmodule
